// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the imem request/ready handshake from the current PC,
// loads the IF/ID register, skids one word across decode stalls and squashes wrong-path fetches.
module fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        pc_stall_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        if_id_valid_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc4_o
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

   state_t              state_q;
   logic                vld_p1;
   logic [DATA_W-1:0]   instr_p1;
   logic [DATA_W-1:0]   pc_p1;
   logic [DATA_W-1:0]   pc4_p1;
   logic [DATA_W-1:0]   skid_instr;
   logic [DATA_W-1:0]   skid_pc;
   logic [DATA_W-1:0]   addr_q;

   logic xfer_done;
   logic load_ok;
   logic req_load;
   logic hold_load;

   function automatic logic [DATA_W-1:0] pc_plus4(input logic [DATA_W-1:0] pc);
      return pc + DATA_W'(4);
   endfunction

   always_comb begin
      // The request is gated by reset so memory never sees a request while the stage is held in reset.
      imem_req_o  = rst && (state_q != S_HOLD);
      imem_addr_o = (state_q == S_DROP) ? addr_q : pc_i;
      case (state_q)
         S_REQ:   pc_stall_o = ~imem_ready_i & ~flush_i;
         S_HOLD:  pc_stall_o = ~flush_i;
         default: pc_stall_o = 1'b1;
      endcase
      if (!rst) pc_stall_o = 1'b1;
      xfer_done = imem_req_o & imem_ready_i;
      load_ok   = ~stall_i | ~vld_p1;
      req_load  = (state_q == S_REQ) & xfer_done & ~flush_i & load_ok;
      hold_load = (state_q == S_HOLD) & ~flush_i & ~stall_i;
   end

   // Handshake control, skid buffer and wrong-path address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_REQ;
         skid_instr <= '0;
         skid_pc    <= '0;
         addr_q     <= '0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (xfer_done && !flush_i && !load_ok) begin
                  skid_instr <= imem_rdata_i;
                  skid_pc    <= pc_i;
                  state_q    <= S_HOLD;
               end else if (!xfer_done && flush_i) begin
                  addr_q  <= pc_i;
                  state_q <= S_DROP;
               end
            end
            S_HOLD: begin
               if (flush_i || !stall_i) state_q <= S_REQ;
            end
            S_DROP: begin
               // The in-flight wrong-path word is consumed and thrown away.
               if (xfer_done) state_q <= S_REQ;
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1   <= 1'b0;
         instr_p1 <= NOP_INSTR;
         pc_p1    <= '0;
         pc4_p1   <= '0;
      end else if (flush_i) begin
         vld_p1   <= 1'b0;
         instr_p1 <= NOP_INSTR;
      end else if (req_load) begin
         vld_p1   <= 1'b1;
         instr_p1 <= imem_rdata_i;
         pc_p1    <= pc_i;
         pc4_p1   <= pc_plus4(pc_i);
      end else if (hold_load) begin
         vld_p1   <= 1'b1;
         instr_p1 <= skid_instr;
         pc_p1    <= skid_pc;
         pc4_p1   <= pc_plus4(skid_pc);
      end else if (!stall_i) begin
         vld_p1   <= 1'b0;
         instr_p1 <= NOP_INSTR;
      end
   end

   assign if_id_valid_o = vld_p1;
   assign if_id_instr_o = instr_p1;
   assign if_id_pc_o    = pc_p1;
   assign if_id_pc4_o   = pc4_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a stimulus process pushes expected IF/ID contents into a
// scoreboard queue, and a monitor pops and compares them on every falling edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_stall_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic        stall_i;
   logic        flush_i;
   logic        if_id_valid_o;
   logic [31:0] if_id_instr_o;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   fetch_unit #(.NOP_INSTR(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .pc_stall_o    (pc_stall_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rdata_i  (imem_rdata_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .if_id_valid_o (if_id_valid_o),
      .if_id_instr_o (if_id_instr_o),
      .if_id_pc_o    (if_id_pc_o),
      .if_id_pc4_o   (if_id_pc4_o)
   );

   // Memory returns the word address as the instruction.
   assign imem_rdata_i = imem_addr_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("if_id_valid", {31'd0, if_id_valid_o}, {31'd0, e.v});
         chk("if_id_instr", if_id_instr_o, e.instr);
         chk("if_id_pc",    if_id_pc_o,    e.pc);
         chk("if_id_pc4",   if_id_pc4_o,   e.pc4);
      end
   end

   // Drive one cycle of inputs, check the combinational outputs, queue the IF/ID state expected after the edge.
   task automatic step(input logic rdy, input logic stl, input logic fl, input logic [31:0] pc,
                       input logic e_req, input logic e_pst, input logic [31:0] e_addr,
                       input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_pc4);
      exp_t e;
      imem_ready_i = rdy;
      stall_i      = stl;
      flush_i      = fl;
      pc_i         = pc;
      #1;
      chk("imem_req", {31'd0, imem_req_o}, {31'd0, e_req});
      chk("pc_stall", {31'd0, pc_stall_o}, {31'd0, e_pst});
      if (e_req) chk("imem_addr", imem_addr_o, e_addr);
      e.v     = e_v;
      e.instr = e_v ? e_pc : 32'h0;
      e.pc    = e_pc;
      e.pc4   = e_pc4;
      sb.push_back(e);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst = 1'b1; pc_i = 32'h0; imem_ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("rst_req",   {31'd0, imem_req_o},    32'd0);
      chk("rst_stall", {31'd0, pc_stall_o},    32'd1);
      chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
      chk("rst_instr", if_id_instr_o, 32'h0);
      chk("rst_pc",    if_id_pc_o,    32'h0);
      chk("rst_pc4",   if_id_pc4_o,   32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      //   rdy stl fl  pc              req pst addr            v   pc              pc4
      // zero-wait sequential fetch
      step(1, 0, 0, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0004);
      step(1, 0, 0, 32'h0000_0004, 1, 0, 32'h0000_0004, 1, 32'h0000_0004, 32'h0000_0008);
      step(1, 0, 0, 32'h0000_0008, 1, 0, 32'h0000_0008, 1, 32'h0000_0008, 32'h0000_000C);
      step(1, 0, 0, 32'h0000_000C, 1, 0, 32'h0000_000C, 1, 32'h0000_000C, 32'h0000_0010);
      // two wait cycles: PC held, address stable, IF/ID bubbles
      step(0, 0, 0, 32'h0000_0010, 1, 1, 32'h0000_0010, 0, 32'h0000_000C, 32'h0000_0010);
      step(0, 0, 0, 32'h0000_0010, 1, 1, 32'h0000_0010, 0, 32'h0000_000C, 32'h0000_0010);
      step(1, 0, 0, 32'h0000_0010, 1, 0, 32'h0000_0010, 1, 32'h0000_0010, 32'h0000_0014);
      // decode stall while a fetch completes: skid into HOLD
      step(1, 0, 0, 32'h0000_0014, 1, 0, 32'h0000_0014, 1, 32'h0000_0014, 32'h0000_0018);
      step(1, 1, 0, 32'h0000_0018, 1, 0, 32'h0000_0018, 1, 32'h0000_0014, 32'h0000_0018);
      step(1, 1, 0, 32'h0000_001C, 0, 1, 32'h0000_0000, 1, 32'h0000_0014, 32'h0000_0018);
      step(1, 0, 0, 32'h0000_001C, 0, 1, 32'h0000_0000, 1, 32'h0000_0018, 32'h0000_001C);
      step(1, 0, 0, 32'h0000_001C, 1, 0, 32'h0000_001C, 1, 32'h0000_001C, 32'h0000_0020);
      // flush on a zero-wait fetch, then fetch the branch target
      step(1, 0, 1, 32'h0040_0100, 1, 0, 32'h0040_0100, 0, 32'h0000_001C, 32'h0000_0020);
      step(1, 0, 0, 32'h0810_0000, 1, 0, 32'h0810_0000, 1, 32'h0810_0000, 32'h0810_0004);
      // flush in the first cycle of a 3-cycle fetch at 0x10: DROP keeps address 0x10
      step(0, 0, 1, 32'h0000_0010, 1, 0, 32'h0000_0010, 0, 32'h0810_0000, 32'h0810_0004);
      step(0, 0, 0, 32'h0000_0200, 1, 1, 32'h0000_0010, 0, 32'h0810_0000, 32'h0810_0004);
      step(1, 0, 0, 32'h0000_0200, 1, 1, 32'h0000_0010, 0, 32'h0810_0000, 32'h0810_0004);
      step(1, 0, 0, 32'h0000_0200, 1, 0, 32'h0000_0200, 1, 32'h0000_0200, 32'h0000_0204);
      // PC+4 wraps to zero
      step(1, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000);
      // stall and flush together: flush wins
      step(1, 1, 1, 32'h0000_0000, 1, 0, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h0000_0000);
      // enter HOLD, then assert reset asynchronously
      step(1, 0, 0, 32'h0000_0040, 1, 0, 32'h0000_0040, 1, 32'h0000_0040, 32'h0000_0044);
      step(1, 1, 0, 32'h0000_0044, 1, 0, 32'h0000_0044, 1, 32'h0000_0040, 32'h0000_0044);
      #1;
      chk("hold_req",   {31'd0, imem_req_o}, 32'd0);
      chk("hold_stall", {31'd0, pc_stall_o}, 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", {31'd0, if_id_valid_o}, 32'd0);
      chk("arst_instr", if_id_instr_o, 32'h0);
      chk("arst_pc",    if_id_pc_o,    32'h0);
      chk("arst_req",   {31'd0, imem_req_o}, 32'd0);
      chk("arst_stall", {31'd0, pc_stall_o}, 32'd1);
      stall_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1, 0, 0, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0004);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of `PC`: takes the current program counter, runs a request/ready handshake with instruction memory, and loads the IF/ID pipeline register. Stalls the PC while memory is busy, buffers one instruction when the decode side stalls mid-transaction, and discards wrong-path fetches on branch/jump flush.

## Interface
- `NOP_INSTR`, default `32'h00000000`: instruction value driven into IF/ID on reset, flush or bubble.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  32  current PC (`PC.pc_o`).
- `pc_stall_o`  out  1  1 = PC must hold its value this cycle; 0 = PC updates per `PCSrc`.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch word address.
- `imem_ready_i`  in  1  memory completes the transfer this cycle.
- `imem_rdata_i`  in  32  instruction; valid when `imem_req_o & imem_ready_i`.
- `stall_i`  in  1  hazard unit: hold IF/ID contents.
- `flush_i`  in  1  branch/jump taken (`PCSrc != 2'b00`): squash the fetch path.
- `if_id_valid_o`  out  1  IF/ID holds a real instruction.
- `if_id_instr_o`  out  32  fetched instruction.
- `if_id_pc_o`  out  32  address it was fetched from.
- `if_id_pc4_o`  out  32  that address + 4 (mod 2^32).

## Operation
- Transfer completes on any edge with `imem_req_o & imem_ready_i`. Once raised, `imem_req_o` stays high with `imem_addr_o` stable until completion. Memory may answer in the same cycle (zero-wait) or after N wait cycles.
- `load_ok = ~stall_i | ~if_id_valid_o`.
- The FSM has three states: REQ, HOLD and DROP.
- REQ:
  - `imem_req_o = 1`, `imem_addr_o = pc_i`, `pc_stall_o = ~imem_ready_i & ~flush_i`.
  - Completion, no flush, `load_ok`: load IF/ID with {rdata, `pc_i`, `pc_i+4`}, valid=1. Stay in REQ.
  - Completion, no flush, `~load_ok`: capture {rdata, `pc_i`} into the skid register and go to HOLD.
  - Completion with flush: discard the data. Stay in REQ.
  - No completion with flush: latch `pc_i` into `addr_q` and go to DROP.
- HOLD:
  - `imem_req_o = 0`, `pc_stall_o = ~flush_i`.
  - `~stall_i`: move skid into IF/ID, valid=1, then go to REQ.
  - `flush_i`: drop the skid and go to REQ.
- DROP:
  - `imem_req_o = 1`, `imem_addr_o = addr_q`, `pc_stall_o = 1`.
  - Completion: discard the data and go to REQ, which fetches the new `pc_i`.
  - `flush_i` in DROP has no additional effect. The PC already advanced on the flush cycle, and the last flush target wins in PC.
- IF/ID update priority, evaluated each edge:
  1. `flush_i`: valid=0, instr=`NOP_INSTR`. The PC fields hold.
  2. Load as listed above.
  3. `~stall_i` with no load: bubble (valid=0, instr=`NOP_INSTR`).
  4. Otherwise: hold.
- `if_id_pc4_o` is computed with 32-bit wrap: `32'hFFFFFFFC` gives `32'h00000000`.

## Timing
- Reset (async assert, sync-to-clk release): state REQ, `if_id_valid_o=0`, `if_id_instr_o=NOP_INSTR`, `if_id_pc_o=0`, `if_id_pc4_o=0`, skid and `addr_q` = 0.
- During reset, `imem_req_o=0` and `pc_stall_o=1`. `imem_req_o` goes to 1 in the first cycle after release.
- Latency: with zero-wait memory, IF/ID shows the instruction at `pc_i` one edge after it is presented. Throughput is 1 instr/cycle.
- With N wait cycles, the PC is held for N cycles and IF/ID bubbles during the wait unless stalled.
- `pc_stall_o` is combinational from `imem_ready_i`, `flush_i` and state. No combinational path exists from `imem_rdata_i` to any output.
- Stall and flush in the same cycle: flush wins.
- Reset mid-transaction: the outstanding request is abandoned with no handshake. The memory must tolerate `imem_req_o` dropping under reset.

## Test plan
- **Reset, then zero-wait sequential fetch.** Release `rst`, with `imem_ready_i=1` and memory returning `{addr}` as data.
  - Cycle 1: IF/ID = {instr `32'h0`, pc 0, pc4 4, valid 1}.
  - Next cycles: pc 4, 8, C, with `pc_stall_o` = 0 throughout.
- **Wait states.** Memory takes 2 cycles per fetch.
  - `pc_stall_o=1` and `imem_addr_o` stable for 2 cycles.
  - IF/ID bubbles (valid 0, instr 0), then loads.
- **Stall while in flight.** `stall_i=1` with IF/ID valid at pc 4, and the fetch at 8 completes.
  - IF/ID holds pc 4 and the FSM enters HOLD.
  - On `stall_i=0`, IF/ID becomes pc 8 and `imem_req_o` resumes at C.
- **Flush with zero-wait.** `flush_i=1` while fetching `32'h00400100`.
  - IF/ID valid=0 next edge, `pc_stall_o=0`.
  - The next fetch address equals the target the PC loads, e.g. `32'h08100000`.
- **Flush during a wait state.** Flush in cycle 1 of a 3-cycle fetch at `32'h10`.
  - The FSM enters DROP and `imem_addr_o` stays `32'h10` until ready.
  - The data is discarded, then the FSM fetches the branch target.
- **Wrap and async reset.**
  - `pc_i=32'hFFFFFFFC` gives `if_id_pc4_o=0`.
  - Asserting `rst` mid-HOLD clears valid immediately, before the next clock edge.
